// File: rtl/core_lsu.sv
// Load/store unit: turns EX-stage memory ops into aligned req/gnt bus beats and
// aligns and extends load data for writeback. Word-crossing accesses take two beats.
module core_lsu #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              stall_o,
  output logic              misaligned_o,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              req_dmem_o,
  input  logic              gnt_dmem_i,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wr_data_o,
  output logic [XLEN/8-1:0] data_size_o,
  output logic              data_read_o,
  output logic              data_write_o,
  input  logic [XLEN-1:0]   data_rd_data_i
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int LB = $clog2(XLEN);

  typedef enum logic {B1, B2} state_t;
  state_t state_q, state_d;

  logic [OB-1:0]   off;
  logic [OB:0]     nbytes;
  logic [2*NB-1:0] lane_base, mask2;
  logic            crosses, reject, fin_read;
  logic [XLEN-1:0] aligned;
  logic [OB+3:0]   hi_shift;

  logic            b2_first_q, rsp_vld_q, rsp_uns_q, rsp_split_q;
  logic [OB-1:0]   rsp_off_q;
  logic [1:0]      rsp_size_q;
  logic [XLEN-1:0] lo_q;

  assign off       = req_addr_i[OB-1:0];
  assign nbytes    = (OB+1)'(1) << req_size_i;
  assign lane_base = ((2*NB)'(1) << nbytes) - (2*NB)'(1);
  assign mask2     = lane_base << off;
  assign crosses   = |mask2[2*NB-1:NB];
  assign reject    = !SPLIT_MISALIGNED && crosses;
  assign aligned   = {req_addr_i[XLEN-1:OB], OB'(0)};
  // Second beat carries the bytes that spilled past the first word.
  assign hi_shift  = {(OB+1)'(NB) - {1'b0, off}, 3'b000};

  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    misaligned_o   = 1'b0;
    req_dmem_o     = 1'b0;
    data_addr_o    = '0;
    data_wr_data_o = '0;
    data_size_o    = '0;
    data_read_o    = 1'b0;
    data_write_o   = 1'b0;
    fin_read       = 1'b0;
    case (state_q)
      B1: begin
        if (req_valid_i && reject) begin
          misaligned_o = 1'b1;
        end else if (req_valid_i) begin
          req_dmem_o     = 1'b1;
          data_addr_o    = aligned;
          data_size_o    = mask2[NB-1:0];
          data_wr_data_o = req_wdata_i << {off, 3'b000};
          data_read_o    = !req_write_i;
          data_write_o   = req_write_i;
          if (!gnt_dmem_i) begin
            stall_o = 1'b1;
          end else if (crosses) begin
            stall_o = 1'b1;
            state_d = B2;
          end else begin
            fin_read = !req_write_i;
          end
        end
      end
      B2: begin
        req_dmem_o     = 1'b1;
        data_addr_o    = aligned + XLEN'(NB);
        data_size_o    = mask2[2*NB-1:NB];
        data_wr_data_o = req_wdata_i >> hi_shift;
        data_read_o    = !req_write_i;
        data_write_o   = req_write_i;
        if (gnt_dmem_i) begin
          state_d  = B1;
          fin_read = !req_write_i;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = B1;
    endcase
    // Reset must silence the bus at once, even with a request still presented.
    if (!rst_ni) begin
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      req_dmem_o   = 1'b0;
      data_addr_o  = '0;
      data_wr_data_o = '0;
      data_size_o  = '0;
      data_read_o  = 1'b0;
      data_write_o = 1'b0;
      fin_read     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= B1;
      b2_first_q  <= 1'b0;
      lo_q        <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_off_q   <= '0;
      rsp_size_q  <= '0;
      rsp_uns_q   <= 1'b0;
      rsp_split_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b2_first_q <= (state_q == B1) && (state_d == B2);
      if (b2_first_q) lo_q <= data_rd_data_i;
      rsp_vld_q <= fin_read;
      if (fin_read) begin
        rsp_off_q   <= off;
        rsp_size_q  <= req_size_i;
        rsp_uns_q   <= req_unsigned_i;
        rsp_split_q <= (state_q == B2);
      end
    end
  end

  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   raw, ext;
  logic [OB:0]       rsp_nbytes;
  logic [OB+3:0]     top_bit_w;
  logic              sbit;

  always_comb begin
    pair       = {data_rd_data_i, lo_q} >> {rsp_off_q, 3'b000};
    raw        = rsp_split_q ? pair[XLEN-1:0] : (data_rd_data_i >> {rsp_off_q, 3'b000});
    rsp_nbytes = (OB+1)'(1) << rsp_size_q;
    top_bit_w  = {rsp_nbytes, 3'b000} - (OB+4)'(1);
    sbit       = raw[top_bit_w[LB-1:0]] & !rsp_uns_q;
    ext        = '0;
    for (int j = 0; j < XLEN; j++) begin
      ext[j] = (j < 8 * int'(rsp_nbytes)) ? raw[j] : sbit;
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rsp_vld_q ? ext : '0;

  a_size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_valid_i && (XLEN == 32) && (req_size_i == 2'd3)));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    stall_o |=> $stable({req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i}));
endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu (XLEN=32): expected beats/responses queued by stimulus, checked by a monitor.
module tb_core_lsu;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0, req_valid_ns = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rd_data = '0;
  logic [1:0]  req_size = '0;
  logic        gnt = 1'b0;

  logic        stall, misaligned, rsp_valid, req_dmem, data_read, data_write;
  logic [31:0] rsp_rdata, data_addr, data_wr_data;
  logic [3:0]  data_size;
  logic        stall_ns, misaligned_ns, rsp_valid_ns, req_dmem_ns, data_read_ns, data_write_ns;
  logic [31:0] rsp_rdata_ns, data_addr_ns, data_wr_data_ns;
  logic [3:0]  data_size_ns;

  always #5 clk = ~clk;

  core_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .stall_o(stall), .misaligned_o(misaligned),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .req_dmem_o(req_dmem),
    .gnt_dmem_i(gnt), .data_addr_o(data_addr), .data_wr_data_o(data_wr_data),
    .data_size_o(data_size), .data_read_o(data_read), .data_write_o(data_write),
    .data_rd_data_i(rd_data));

  core_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_ns), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .stall_o(stall_ns), .misaligned_o(misaligned_ns),
    .rsp_valid_o(rsp_valid_ns), .rsp_rdata_o(rsp_rdata_ns), .req_dmem_o(req_dmem_ns),
    .gnt_dmem_i(gnt), .data_addr_o(data_addr_ns), .data_wr_data_o(data_wr_data_ns),
    .data_size_o(data_size_ns), .data_read_o(data_read_ns), .data_write_o(data_write_ns),
    .data_rd_data_i(rd_data));

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] mem [logic [31:0]];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic wr);
    beat_t b;
    b.addr = a; b.be = be; b.wdata = wd; b.wr = wr;
    beat_q.push_back(b);
  endtask

  // Data memory: read data appears one cycle after a granted read beat.
  always @(posedge clk) begin
    rd_data <= 32'hA5A5_5A5A;
    if (rst_ni && req_dmem && gnt) begin
      if (data_read) rd_data <= mem.exists(data_addr) ? mem[data_addr] : 32'h0;
      if (data_write) begin
        logic [31:0] w;
        w = mem.exists(data_addr) ? mem[data_addr] : 32'h0;
        for (int k = 0; k < 4; k++) if (data_size[k]) w[8*k +: 8] = data_wr_data[8*k +: 8];
        mem[data_addr] = w;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni && req_dmem) begin
      if (beat_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_beat: got addr 0x%08h, expected no beat", data_addr);
      end else begin
        beat_t b;
        b = beat_q[0];
        chk("beat_addr", data_addr, b.addr);
        chk("beat_be", {28'h0, data_size}, {28'h0, b.be});
        chk("beat_wdata", data_wr_data, b.wdata);
        chk("beat_write", {31'h0, data_write}, {31'h0, b.wr});
        chk("beat_read", {31'h0, data_read}, {31'h0, !b.wr});
        if (gnt) void'(beat_q.pop_front());
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_rdata);
      end else begin
        chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input logic u, input logic [7:0] gpat, input int exp_stall);
    int  n = 0;
    bit  done = 0;
    logic st;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
    for (int c = 0; c < 16 && !done; c++) begin
      gnt = (c > 7) ? 1'b1 : gpat[c[2:0]];
      @(negedge clk);
      st = stall;
      @(posedge clk); #1;
      if (st) n++; else done = 1;
    end
    chk($sformatf("stall_cycles@%08h", a), n, exp_stall);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; gnt = 1'b0; req_wdata = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_dmem", {31'h0, req_dmem}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_data_addr", data_addr, 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    idle(1);

    mem[32'h100] = 32'hDEADBEEF;
    push_beat(32'h100, 4'b1111, 32'h0, 1'b0); rsp_q.push_back(32'hDEADBEEF);
    do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 8'hFF, 0);
    push_beat(32'h100, 4'b1000, 32'hAB000000, 1'b1);
    do_op(1'b1, 32'h103, 32'h000000AB, 2'd0, 1'b0, 8'hFF, 0);
    push_beat(32'h100, 4'b1000, 32'h0, 1'b0); rsp_q.push_back(32'h000000AB);
    do_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 8'hFF, 0);
    idle(2);

    mem[32'h100] = 32'h11223344; mem[32'h104] = 32'h55667788;
    push_beat(32'h100, 4'b1100, 32'h0, 1'b0); push_beat(32'h104, 4'b0011, 32'h0, 1'b0);
    rsp_q.push_back(32'h77881122);
    do_op(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 8'hFF, 1);
    push_beat(32'h100, 4'b1100, 32'hBABE0000, 1'b1); push_beat(32'h104, 4'b0011, 32'h0000CAFE, 1'b1);
    do_op(1'b1, 32'h102, 32'hCAFEBABE, 2'd2, 1'b0, 8'hFF, 1);
    push_beat(32'h100, 4'b1100, 32'h0, 1'b0); push_beat(32'h104, 4'b0011, 32'h0, 1'b0);
    rsp_q.push_back(32'hCAFEBABE);
    do_op(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 8'hFF, 1);
    idle(2);

    push_beat(32'h200, 4'b1111, 32'h12345678, 1'b1);
    do_op(1'b1, 32'h200, 32'h12345678, 2'd2, 1'b0, 8'hF8, 3);
    idle(2);

    mem[32'h104] = 32'h80011234;
    push_beat(32'h104, 4'b1100, 32'h0, 1'b0); rsp_q.push_back(32'hFFFF8001);
    do_op(1'b0, 32'h106, 32'h0, 2'd1, 1'b0, 8'hFF, 0);
    push_beat(32'h104, 4'b1100, 32'h0, 1'b0); rsp_q.push_back(32'h00008001);
    do_op(1'b0, 32'h106, 32'h0, 2'd1, 1'b1, 8'hFF, 0);
    push_beat(32'h104, 4'b1000, 32'h0, 1'b0); rsp_q.push_back(32'hFFFFFF80);
    do_op(1'b0, 32'h107, 32'h0, 2'd0, 1'b0, 8'hFF, 0);
    push_beat(32'h104, 4'b0010, 32'h0, 1'b0); rsp_q.push_back(32'h00000012);
    do_op(1'b0, 32'h105, 32'h0, 2'd0, 1'b1, 8'hFF, 0);
    push_beat(32'h100, 4'b1000, 32'h0, 1'b0); push_beat(32'h104, 4'b0001, 32'h0, 1'b0);
    rsp_q.push_back(32'h000034BA);
    do_op(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, 8'hF9, 3);
    idle(3);

    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h101;
    req_valid_ns = 1'b1; gnt = 1'b1;
    @(negedge clk);
    chk("reject_misaligned", {31'h0, misaligned_ns}, 32'h1);
    chk("reject_req_dmem", {31'h0, req_dmem_ns}, 32'h0);
    chk("reject_stall", {31'h0, stall_ns}, 32'h0);
    @(posedge clk); #1 req_addr = 32'h104;
    @(negedge clk);
    chk("aligned_ns_misaligned", {31'h0, misaligned_ns}, 32'h0);
    chk("aligned_ns_req_dmem", {31'h0, req_dmem_ns}, 32'h1);
    @(posedge clk); #1 req_valid_ns = 1'b0;
    idle(2);

    push_beat(32'h100, 4'b1100, 32'h0, 1'b0); push_beat(32'h104, 4'b0011, 32'h0, 1'b0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h102; req_size = 2'd2; gnt = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 gnt = 1'b0;
    @(negedge clk);
    chk("abort_b2_req_dmem", {31'h0, req_dmem}, 32'h1);
    chk("abort_b2_stall", {31'h0, stall}, 32'h1);
    #1 rst_ni = 1'b0;
    #1;
    chk("abort_reset_req_dmem", {31'h0, req_dmem}, 32'h0);
    chk("abort_reset_stall", {31'h0, stall}, 32'h0);
    beat_q.delete();
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    idle(1);
    push_beat(32'h100, 4'b1111, 32'h0, 1'b0); rsp_q.push_back(32'hBABE3344);
    do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 8'hFF, 0);
    idle(3);

    chk("beats_drained", beat_q.size(), 0);
    chk("rsps_drained", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
